sample_walker: RTL and testbench

Sample-stream transmitter for the rasterizer back end. It accepts one bounded triangle per handshake from the bounding-box stage, then walks every sample position inside the box in raster order, one per cycle. Each cycle it presents the sample location, triangle and colour to the sample-test stage. It stalls the upstream stage with `halt_R13H` while a triangle is still being walked.

---
 rtl/rast_pkg.sv | 30 +++
 rtl/dff.sv | 18 +
 rtl/sample_walker.sv | 100 ++++++++++
 tb/tb_sample_walker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// Shared rasterizer types: walker state, MSAA one-hot codes and step decode.
package rast_pkg;

    localparam int unsigned SIGFIG_W = 24;

    localparam logic [3:0] MSAA_1X  = 4'b1000;
    localparam logic [3:0] MSAA_4X  = 4'b0100;
    localparam logic [3:0] MSAA_16X = 4'b0010;
    localparam logic [3:0] MSAA_64X = 4'b0001;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } walk_state_t;

    // Sample pitch in fixed point: one pixel shifted down by log4 of the sample count.
    function automatic logic [SIGFIG_W-1:0] step_from_subsample(input logic [3:0] sub_sample,
                                                                 input int unsigned radix);
        int unsigned k;
        case (sub_sample)
            MSAA_1X:  k = 0;
            MSAA_4X:  k = 1;
            MSAA_16X: k = 2;
            MSAA_64X: k = 3;
            default:  k = 0;
        endcase
        return SIGFIG_W'(1) << (radix - k);
    endfunction

endpackage

// File: rtl/dff.sv
// Generic register with synchronous active-high reset; RETIME_STATUS != 0 drops the reset.
module dff #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned RETIME_STATUS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Single register stage.
    always_ff @(posedge clk) begin
        if (reset && (RETIME_STATUS == 0)) q <= '0;
        else                               q <= d;
    end

endmodule

// File: rtl/sample_walker.sv
// Walks every sample inside an accepted triangle's bounding box in raster order.
module sample_walker
    import rast_pkg::*;
#(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R13U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R13S,
    input  logic                                           validTri_R13H,
    input  logic        [3:0]                              subSample_RnnnnU,
    output logic                                           halt_R13H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
    output logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
    output logic signed [1:0][SIGFIG-1:0]                  sample_R14S,
    output logic                                           validSamp_R14H
);

    localparam int unsigned TRI_W  = VERTS * AXIS * SIGFIG;
    localparam int unsigned COL_W  = COLORS * SIGFIG;
    localparam int unsigned BOX_W  = 4 * SIGFIG;
    localparam int unsigned SAMP_W = 2 * SIGFIG;

    walk_state_t state;
    walk_state_t state_next;
    logic [0:0]  state_q;

    logic [1:0][1:0][SIGFIG-1:0]          box;
    logic [1:0][1:0][SIGFIG-1:0]          box_next;
    logic [SIGFIG-1:0]                    step;
    logic [SIGFIG-1:0]                    step_next;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_next;
    logic [COLORS-1:0][SIGFIG-1:0]        color_next;
    logic [1:0][SIGFIG-1:0]               sample_next;
    logic                                 valid_next;

    logic x_lt;
    logic y_lt;
    logic at_last;
    logic accept;

    assign state   = walk_state_t'(state_q);
    assign x_lt    = $signed(sample_R14S[0]) < $signed(box[1][0]);
    assign y_lt    = $signed(sample_R14S[1]) < $signed(box[1][1]);
    assign at_last = (state == TEST_STATE) && !x_lt && !y_lt;

    // Upstream holds while a walk has more samples to emit.
    assign halt_R13H = (state == TEST_STATE) && !at_last;
    assign accept    = validTri_R13H && !halt_R13H;

    // Next-state: accept always walks; the last sample without a new triangle idles.
    always_comb begin
        state_next = state;
        if (accept)                                  state_next = TEST_STATE;
        else if ((state == TEST_STATE) && at_last)   state_next = WAIT_STATE;
    end

    // Output/datapath next values: load on accept, otherwise advance in raster order.
    always_comb begin
        tri_next    = tri_R14S;
        color_next  = color_R14U;
        box_next    = box;
        step_next   = step;
        sample_next = sample_R14S;
        valid_next  = validSamp_R14H;
        if (accept) begin
            tri_next       = tri_R13S;
            color_next     = color_R13U;
            box_next       = box_R13S;
            step_next      = SIGFIG'(step_from_subsample(subSample_RnnnnU, RADIX));
            sample_next[0] = box_R13S[0][0];
            sample_next[1] = box_R13S[0][1];
            valid_next     = 1'b1;
        end else if (state == TEST_STATE) begin
            if (x_lt) begin
                sample_next[0] = sample_R14S[0] + step;
            end else if (y_lt) begin
                sample_next[0] = box[0][0];
                sample_next[1] = sample_R14S[1] + step;
            end else begin
                valid_next = 1'b0;
            end
        end
    end

    dff #(.WIDTH(1),      .RETIME_STATUS(0)) u_state (.clk(clk), .reset(rst), .d(state_next),  .q(state_q));
    dff #(.WIDTH(1),      .RETIME_STATUS(0)) u_valid (.clk(clk), .reset(rst), .d(valid_next),  .q(validSamp_R14H));
    dff #(.WIDTH(TRI_W),  .RETIME_STATUS(0)) u_tri   (.clk(clk), .reset(rst), .d(tri_next),    .q(tri_R14S));
    dff #(.WIDTH(COL_W),  .RETIME_STATUS(0)) u_color (.clk(clk), .reset(rst), .d(color_next),  .q(color_R14U));
    dff #(.WIDTH(BOX_W),  .RETIME_STATUS(0)) u_box   (.clk(clk), .reset(rst), .d(box_next),    .q(box));
    dff #(.WIDTH(SIGFIG), .RETIME_STATUS(0)) u_step  (.clk(clk), .reset(rst), .d(step_next),   .q(step));
    dff #(.WIDTH(SAMP_W), .RETIME_STATUS(0)) u_samp  (.clk(clk), .reset(rst), .d(sample_next), .q(sample_R14S));

endmodule

// File: tb/tb_sample_walker.sv
// Directed bench for sample_walker: reset, 1x/4x walks, single sample, back-to-back, MSAA change, mid-walk reset.
module tb_sample_walker;
    import rast_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic signed [2:0][2:0][23:0] tri_in;
    logic        [2:0][23:0]      color_in;
    logic signed [1:0][1:0][23:0] box_in;
    logic                         valid_tri;
    logic        [3:0]            sub_in;
    logic                         halt;
    logic signed [2:0][2:0][23:0] tri_out;
    logic        [2:0][23:0]      color_out;
    logic signed [1:0][23:0]      sample;
    logic                         valid_samp;

    int errors = 0;
    int checks = 0;

    sample_walker dut (
        .clk(clk), .rst(rst),
        .tri_R13S(tri_in), .color_R13U(color_in), .box_R13S(box_in),
        .validTri_R13H(valid_tri), .subSample_RnnnnU(sub_in),
        .halt_R13H(halt), .tri_R14S(tri_out), .color_R14U(color_out),
        .sample_R14S(sample), .validSamp_R14H(valid_samp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0][2:0][23:0] mk_tri(input int base);
        logic [2:0][2:0][23:0] t;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                t[v][a] = 24'(base + v * 16 + a);
        return t;
    endfunction

    function automatic logic [2:0][23:0] mk_col(input int base);
        logic [2:0][23:0] c;
        for (int i = 0; i < 3; i++) c[i] = 24'(base + i);
        return c;
    endfunction

    function automatic logic [1:0][1:0][23:0] mk_box(input int llx, input int lly, input int urx, input int ury);
        logic [1:0][1:0][23:0] b;
        b[0][0] = 24'(llx); b[0][1] = 24'(lly);
        b[1][0] = 24'(urx); b[1][1] = 24'(ury);
        return b;
    endfunction

    function automatic logic [1:0][23:0] mk_pt(input int x, input int y);
        logic [1:0][23:0] p;
        p[0] = 24'(x); p[1] = 24'(y);
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid_tri = 1'b0; sub_in = MSAA_1X;
        tri_in = mk_tri(7); color_in = mk_col(9); box_in = mk_box(0, 0, 1024, 1024);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_samp); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
        checks++; if (sample !== 48'h0) begin errors++; $display("FAIL reset_sample: got %h expected 0", sample); end
        checks++; if (tri_out !== 216'h0) begin errors++; $display("FAIL reset_tri: got %h expected 0", tri_out); end
        checks++; if (color_out !== 72'h0) begin errors++; $display("FAIL reset_color: got %h expected 0", color_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_1x();
        int ex[4] = '{0, 1024, 0, 1024};
        int ey[4] = '{0, 0, 1024, 1024};
        tri_in = mk_tri(100); color_in = mk_col(200); box_in = mk_box(0, 0, 1024, 1024);
        sub_in = MSAA_1X; valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt(ex[i], ey[i])) begin errors++; $display("FAIL 1x_sample[%0d]: got %h expected %h", i, sample, mk_pt(ex[i], ey[i])); end
            checks++; if (valid_samp !== 1'b1) begin errors++; $display("FAIL 1x_valid[%0d]: got %b expected 1", i, valid_samp); end
            checks++; if (halt !== (i < 3)) begin errors++; $display("FAIL 1x_halt[%0d]: got %b expected %b", i, halt, (i < 3)); end
            checks++; if (tri_out !== mk_tri(100) || color_out !== mk_col(200)) begin errors++; $display("FAIL 1x_tri[%0d]: got %h/%h expected %h/%h", i, tri_out, color_out, mk_tri(100), mk_col(200)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL 1x_end_valid: got %b expected 0", valid_samp); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL 1x_end_halt: got %b expected 0", halt); end
    endtask

    task automatic test_4x();
        tri_in = mk_tri(300); color_in = mk_col(400); box_in = mk_box(0, 0, 1024, 1024);
        sub_in = MSAA_4X; valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt((i % 3) * 512, (i / 3) * 512)) begin errors++; $display("FAIL 4x_sample[%0d]: got %h expected %h", i, sample, mk_pt((i % 3) * 512, (i / 3) * 512)); end
            checks++; if (valid_samp !== 1'b1 || halt !== (i < 8)) begin errors++; $display("FAIL 4x_flags[%0d]: got v=%b h=%b expected v=1 h=%b", i, valid_samp, halt, (i < 8)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL 4x_end_valid: got %b expected 0", valid_samp); end
    endtask

    task automatic test_single();
        tri_in = mk_tri(500); color_in = mk_col(600); box_in = mk_box(2048, 3072, 2048, 3072);
        sub_in = MSAA_1X; valid_tri = 1'b1;
        @(negedge clk);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL single_pre_halt: got %b expected 0", halt); end
        @(posedge clk); #1 valid_tri = 1'b0;
        @(negedge clk);
        checks++; if (sample !== mk_pt(2048, 3072) || valid_samp !== 1'b1) begin errors++; $display("FAIL single_sample: got %h v=%b expected %h v=1", sample, valid_samp, mk_pt(2048, 3072)); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL single_halt: got %b expected 0", halt); end
        checks++; if (tri_out !== mk_tri(500)) begin errors++; $display("FAIL single_tri: got %h expected %h", tri_out, mk_tri(500)); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL single_end: got v=%b h=%b expected v=0 h=0", valid_samp, halt); end
    endtask

    task automatic test_back_to_back();
        int ex[4]  = '{0, 1024, 0, 1024};
        int eh[4]  = '{1, 0, 1, 0};
        int etb[4] = '{700, 700, 800, 800};
        tri_in = mk_tri(700); color_in = mk_col(710); box_in = mk_box(0, 0, 1024, 0);
        sub_in = MSAA_1X; valid_tri = 1'b1;
        @(posedge clk); #1;
        tri_in = mk_tri(800); color_in = mk_col(810);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt(ex[i], 0) || valid_samp !== 1'b1) begin errors++; $display("FAIL b2b_sample[%0d]: got %h v=%b expected %h v=1", i, sample, valid_samp, mk_pt(ex[i], 0)); end
            checks++; if (halt !== 1'(eh[i])) begin errors++; $display("FAIL b2b_halt[%0d]: got %b expected %0d", i, halt, eh[i]); end
            checks++; if (tri_out !== mk_tri(etb[i]) || color_out !== mk_col(etb[i] + 10)) begin errors++; $display("FAIL b2b_tri[%0d]: got %h/%h expected %h/%h", i, tri_out, color_out, mk_tri(etb[i]), mk_col(etb[i] + 10)); end
            @(posedge clk); #1;
            if (i == 1) valid_tri = 1'b0;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b expected 0", valid_samp); end
    endtask

    task automatic test_msaa_change();
        tri_in = mk_tri(900); color_in = mk_col(910); box_in = mk_box(0, 0, 2048, 0);
        sub_in = MSAA_1X; valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0; sub_in = MSAA_64X;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt(i * 1024, 0) || halt !== (i < 2)) begin errors++; $display("FAIL msaa_hold[%0d]: got %h h=%b expected %h h=%b", i, sample, halt, mk_pt(i * 1024, 0), (i < 2)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL msaa_end_valid: got %b expected 0", valid_samp); end
        box_in = mk_box(0, 0, 128, 0); valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt(i * 128, 0) || valid_samp !== 1'b1) begin errors++; $display("FAIL msaa_64x[%0d]: got %h v=%b expected %h v=1", i, sample, valid_samp, mk_pt(i * 128, 0)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL msaa_64x_end: got %b expected 0", valid_samp); end
    endtask

    task automatic test_reset_midwalk();
        tri_in = mk_tri(1000); color_in = mk_col(1010); box_in = mk_box(0, 0, 1024, 1024);
        sub_in = MSAA_1X; valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0;
        @(negedge clk);
        checks++; if (valid_samp !== 1'b1 || halt !== 1'b1) begin errors++; $display("FAIL rstmid_c1: got v=%b h=%b expected v=1 h=1", valid_samp, halt); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (sample !== mk_pt(1024, 0)) begin errors++; $display("FAIL rstmid_c2: got %h expected %h", sample, mk_pt(1024, 0)); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got v=%b h=%b expected v=0 h=0", valid_samp, halt); end
        checks++; if (dut.state !== WAIT_STATE) begin errors++; $display("FAIL rstmid_state: got %b expected %b", dut.state, WAIT_STATE); end
        checks++; if (sample !== 48'h0 || tri_out !== 216'h0 || color_out !== 72'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h/%h expected zeros", sample, tri_out, color_out); end
        tri_in = mk_tri(1100); color_in = mk_col(1110); box_in = mk_box(0, 0, 1024, 0); valid_tri = 1'b1;
        @(posedge clk); #1 valid_tri = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (sample !== mk_pt(i * 1024, 0) || valid_samp !== 1'b1 || tri_out !== mk_tri(1100)) begin errors++; $display("FAIL rstmid_next[%0d]: got %h v=%b expected %h v=1", i, sample, valid_samp, mk_pt(i * 1024, 0)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (valid_samp !== 1'b0) begin errors++; $display("FAIL rstmid_next_end: got %b expected 0", valid_samp); end
    endtask

    initial begin
        rst = 1'b1; valid_tri = 1'b0; sub_in = MSAA_1X;
        tri_in = '0; color_in = '0; box_in = '0;
        test_reset();
        test_1x();
        test_4x();
        test_single();
        test_back_to_back();
        test_msaa_change();
        test_reset_midwalk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
